// File: rtl/multi_tick_gen.sv
// Multi-channel runtime-programmable tick generator: each channel emits a one-cycle
// tick every N enabled cycles, periodic or one-shot, with N loadable per channel.
module multi_tick_gen #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned DEFAULT_PERIOD = 148_500_000,
  parameter int unsigned CH_W           = 4
) (
  input  logic              clk_148Mhz,
  input  logic              reset,
  input  logic [NUM_CH-1:0] enable,
  input  logic [NUM_CH-1:0] oneshot,
  input  logic              load,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [CNT_W-1:0]  load_period,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] done,
  output logic [NUM_CH-1:0] busy
);

  localparam logic [CNT_W-1:0] ResetPeriod = CNT_W'(DEFAULT_PERIOD);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic             r_done;
    logic             r_busy;

    logic [CNT_W-1:0] w_period_d;
    logic [CNT_W-1:0] w_cnt_d;
    logic             w_tick_d;
    logic             w_done_d;
    logic             w_busy_d;
    logic             w_load_hit;
    logic             w_terminal;

    assign w_load_hit = load && (load_ch == CH_W'(g));
    assign w_terminal = (r_cnt == r_period - CNT_W'(1));

    // Load beats everything, including a terminal count landing on the same edge.
    always_comb begin
      w_period_d = r_period;
      w_cnt_d    = r_cnt;
      w_tick_d   = 1'b0;
      w_done_d   = r_done;
      if (w_load_hit) begin
        w_period_d = load_period;
        w_cnt_d    = '0;
        w_done_d   = 1'b0;
      end else if (!enable[g]) begin
        w_cnt_d    = '0;
        w_done_d   = 1'b0;
      end else if ((r_period == '0) || r_done) begin
        w_cnt_d    = r_cnt;
      end else if (w_terminal) begin
        w_cnt_d    = '0;
        w_tick_d   = 1'b1;
        if (oneshot[g]) begin
          w_done_d = 1'b1;
        end
      end else begin
        w_cnt_d    = r_cnt + CNT_W'(1);
      end
    end

    // Busy uses next-state period/done so it lines up with tick and done.
    assign w_busy_d = enable[g] && (w_period_d != '0) && !w_done_d;

    always_ff @(posedge clk_148Mhz or posedge reset) begin
      if (reset) begin
        r_period <= ResetPeriod;
        r_cnt    <= '0;
        r_tick   <= 1'b0;
        r_done   <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        r_period <= w_period_d;
        r_cnt    <= w_cnt_d;
        r_tick   <= w_tick_d;
        r_done   <= w_done_d;
        r_busy   <= w_busy_d;
      end
    end

    assign tick[g] = r_tick;
    assign done[g] = r_done;
    assign busy[g] = r_busy;
  end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Scoreboard bench for multi_tick_gen: stimulus pushes expected tick cycles per channel,
// a negedge monitor pops and compares whenever a tick is presented.
module tb_multi_tick_gen;
  localparam int unsigned NumCh = 4;
  localparam int unsigned CntW  = 32;
  localparam int unsigned ChW   = 4;

  logic             clk;
  logic             reset;
  logic [NumCh-1:0] enable;
  logic [NumCh-1:0] oneshot;
  logic             load;
  logic [ChW-1:0]   load_ch;
  logic [CntW-1:0]  load_period;
  logic [NumCh-1:0] tick;
  logic [NumCh-1:0] done;
  logic [NumCh-1:0] busy;

  int unsigned cyc;
  int          n_checks;
  int          n_errors;
  int unsigned exp_q [NumCh][$];

  multi_tick_gen #(
    .NUM_CH         (NumCh),
    .CNT_W          (CntW),
    .DEFAULT_PERIOD (5),
    .CH_W           (ChW)
  ) dut (
    .clk_148Mhz  (clk),
    .reset       (reset),
    .enable      (enable),
    .oneshot     (oneshot),
    .load        (load),
    .load_ch     (load_ch),
    .load_period (load_period),
    .tick        (tick),
    .done        (done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  // Tick visible at negedge with cyc==k was registered on posedge k.
  always @(negedge clk) begin
    if (!reset) begin
      for (int ch = 0; ch < NumCh; ch++) begin
        while (exp_q[ch].size() > 0 && exp_q[ch][0] < cyc) begin
          n_checks++;
          n_errors++;
          $display("FAIL missed_tick ch%0d: got no tick, required tick at cycle %0d",
                   ch, exp_q[ch][0]);
          void'(exp_q[ch].pop_front());
        end
        if (tick[ch]) begin
          n_checks++;
          if (exp_q[ch].size() > 0 && exp_q[ch][0] == cyc) begin
            void'(exp_q[ch].pop_front());
          end else begin
            n_errors++;
            $display("FAIL unexpected_tick ch%0d: got tick at cycle %0d, required next at %0d",
                     ch, cyc, (exp_q[ch].size() > 0) ? exp_q[ch][0] : 0);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, got, exp);
    end
  endtask

  task automatic wait_cyc(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_ticks(input int ch, input int unsigned first, input int unsigned period,
                            input int n);
    for (int k = 0; k < n; k++) exp_q[ch].push_back(first + period * k);
  endtask

  task automatic do_load(input int unsigned ch, input int unsigned period);
    load        = 1'b1;
    load_ch     = ChW'(ch);
    load_period = period;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b1;
    enable      = '0;
    oneshot     = '0;
    load        = 1'b0;
    load_ch     = '0;
    load_period = '0;

    wait_cyc(3);
    check("reset_tick", 32'(tick), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    reset = 1'b0;

    // Channel 0 on default period 5.
    wait_cyc(4);
    enable = 4'b0001;
    push_ticks(0, 9, 5, 8);  // 9..44
    wait_cyc(5);
    check("busy_ch0_on", 32'(busy), 32'h1);

    // Runtime load of channel 2 with period 3.
    wait_cyc(6);
    do_load(2, 3);
    enable = 4'b0101;
    push_ticks(2, 10, 3, 5);  // 10..22
    wait_cyc(7);
    load = 1'b0;
    wait_cyc(23);
    enable = 4'b0001;

    // One-shot channel 1, period 4.
    wait_cyc(24);
    do_load(1, 4);
    oneshot = 4'b0010;
    enable  = 4'b0011;
    push_ticks(1, 29, 4, 1);
    wait_cyc(25);
    load = 1'b0;
    wait_cyc(30);
    check("oneshot_done", 32'(done), 32'h2);
    check("oneshot_busy", 32'(busy), 32'h1);
    wait_cyc(33);
    check("oneshot_done_hold", 32'(done), 32'h2);

    // Re-arm by dropping enable for one cycle.
    wait_cyc(34);
    enable = 4'b0001;
    wait_cyc(35);
    check("rearm_done_clr", 32'(done), 32'h0);
    enable = 4'b0011;
    push_ticks(1, 39, 4, 1);
    wait_cyc(40);
    check("rearm_done_set", 32'(done), 32'h2);

    // Load ch0 on the edge where its count is terminal: tick suppressed.
    wait_cyc(48);
    do_load(0, 7);
    push_ticks(0, 56, 7, 4);  // 56, 63, 70, 77
    wait_cyc(49);
    load = 1'b0;

    // Period 1 periodic on channel 3.
    wait_cyc(50);
    do_load(3, 1);
    enable = 4'b1011;
    push_ticks(3, 52, 1, 6);  // 52..57
    wait_cyc(51);
    load = 1'b0;
    wait_cyc(57);
    enable = 4'b0011;

    // Period 0 parks channel 2.
    wait_cyc(58);
    do_load(2, 0);
    enable = 4'b0111;
    wait_cyc(59);
    load = 1'b0;
    wait_cyc(62);
    check("park_busy", 32'(busy), 32'h1);
    wait_cyc(65);
    check("park_busy_hold", 32'(busy), 32'h1);

    // Out-of-range channel index is ignored.
    wait_cyc(66);
    do_load(5, 2);
    wait_cyc(67);
    load = 1'b0;
    wait_cyc(68);
    check("bad_ch_done", 32'(done), 32'h2);
    check("bad_ch_busy", 32'(busy), 32'h1);

    // Async reset between edges while a tick is showing.
    wait_cyc(77);
    #1;
    reset = 1'b1;
    #1;
    check("async_tick", 32'(tick), 32'h0);
    check("async_done", 32'(done), 32'h0);
    check("async_busy", 32'(busy), 32'h0);
    enable  = 4'b0001;
    oneshot = '0;
    wait_cyc(80);
    reset = 1'b0;
    push_ticks(0, 85, 5, 2);  // default period restored
    wait_cyc(82);
    check("post_reset_busy", 32'(busy), 32'h1);
    wait_cyc(91);
    enable = '0;

    wait_cyc(100);
    for (int ch = 0; ch < NumCh; ch++) begin
      check($sformatf("queue_empty_ch%0d", ch), 32'(exp_q[ch].size()), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
